pnode_frame_ctrl: RTL and testbench

PNODE_FRAME_CTRL -- requirements
Module: pnode_frame_ctrl

---
 rtl/pnode_frame_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pnode_frame_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pnode_frame_ctrl.sv
// ---------------------------------------------------------------------------
// pnode_frame_ctrl
//
// Frame controller for a two-bit polar-style node decision. It collects
// NPAIR pairs of sign-magnitude LLRs (plus two frozen flags per pair) into
// a local buffer. It then evaluates one buffered pair per cycle into a
// 2*NPAIR-bit decoded frame. Finally it offers that frame on a
// valid/ready handshake.
//
// Ports
//   clk        : single clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : input pair beat offered
//   in_ready   : beat accepted (IDLE / LOAD only)
//   llr_c      : LLR C, sign-magnitude (bit7 = 1 means negative)
//   llr_d      : LLR D, sign-magnitude
//   frozen1    : frozen flag, first bit of the pair
//   frozen2    : frozen flag, second bit of the pair
//   out_valid  : decoded frame available (OUT state)
//   out_ready  : consumer accepts the frame
//   out_bits   : decoded frame, pair k at bits [2k+1:2k]
//   busy       : state is not IDLE
//   frame_cnt  : frames delivered, wraps at 256
// ---------------------------------------------------------------------------
module pnode_frame_ctrl #(
  parameter int NPAIR = 8,
  parameter int CW    = $clog2(NPAIR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           llr_c,
  input  logic [7:0]           llr_d,
  input  logic                 frozen1,
  input  logic                 frozen2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*NPAIR-1:0]   out_bits,
  output logic                 busy,
  output logic [7:0]           frame_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NPAIR - 1);

  // Buffer entry layout: {llr_c[7:0], llr_d[7:0], frozen1, frozen2}.
  function automatic logic [1:0] decide(input logic [17:0] entry);
    logic       hc;
    logic       hd;
    logic       gt;
    logic       f1;
    logic       f2;
    logic [1:0] bits;
    hc      = ~entry[17];
    hd      = ~entry[9];
    gt      = (entry[16:10] > entry[8:2]);
    f1      = entry[1];
    f2      = entry[0];
    bits[0] = ~f1 & (hc ^ hd);
    bits[1] = ~f2 & gt & (hd | (f1 & hc));
    return bits;
  endfunction

  logic [17:0]          buf_r [NPAIR];
  logic [1:0]           state_r;
  logic [1:0]           state_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_s;
  logic                 out_valid_r;
  logic                 out_valid_s;
  logic [7:0]           frame_cnt_r;
  logic [7:0]           frame_cnt_s;
  logic [2*NPAIR-1:0]   out_bits_r;
  logic                 accept_s;
  logic [1:0]           dec_s;

  // in_ready and busy come straight from the state register, never from inputs.
  assign in_ready  = (state_r == ST_IDLE) || (state_r == ST_LOAD);
  assign busy      = (state_r != ST_IDLE);
  assign accept_s  = in_valid & in_ready;
  assign dec_s     = decide(buf_r[cnt_r]);

  assign out_valid = out_valid_r;
  assign out_bits  = out_bits_r;
  assign frame_cnt = frame_cnt_r;

  // Next-state, pair counter, out_valid and frame counter.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    out_valid_s = 1'b0;
    frame_cnt_s = frame_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_LOAD;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          if (cnt_r == CNT_LAST) begin
            cnt_s   = CNT_ZERO;
            state_s = ST_RUN;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s       = CNT_ZERO;
          state_s     = ST_OUT;
          out_valid_s = 1'b1;
        end else begin
          cnt_s       = cnt_r + CNT_ONE;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_s     = ST_IDLE;
          out_valid_s = 1'b0;
          frame_cnt_s = frame_cnt_r + 8'd1;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      out_valid_r <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      out_valid_r <= out_valid_s;
      frame_cnt_r <= frame_cnt_s;
    end
  end

  // Pair buffer. The counter is always zero in IDLE, so cnt_r is the write
  // index for the first beat as well. Contents are not reset: a new frame
  // rewrites every entry before RUN reads any of them.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      buf_r[cnt_r] <= {llr_c, llr_d, frozen1, frozen2};
    end
  end

  // Decoded frame: one pair per RUN cycle, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bits_r <= {(2*NPAIR){1'b0}};
    end else if (state_r == ST_RUN) begin
      out_bits_r[{cnt_r, 1'b0} +: 2] <= dec_s;
    end else begin
      out_bits_r <= out_bits_r;
    end
  end

endmodule

// File: tb/tb_pnode_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pnode_frame_ctrl
//
// Randomised self-checking bench for pnode_frame_ctrl (NPAIR = 8).
// The reference model computes each decoded pair from integer sign and
// magnitude values. Inputs are driven on the falling edge and outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pnode_frame_ctrl;

  localparam int NP    = 8;
  localparam int LIMIT = 4 * NP + 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        llr_c;
  logic [7:0]        llr_d;
  logic              frozen1;
  logic              frozen2;
  logic              out_valid;
  logic              out_ready;
  logic [2*NP-1:0]   out_bits;
  logic              busy;
  logic [7:0]        frame_cnt;

  int                n_total = 0;
  int                n_bad   = 0;
  logic [7:0]        exp_fc;

  // Current frame stimulus.
  logic [7:0]        fc  [NP];
  logic [7:0]        fd  [NP];
  logic              ff1 [NP];
  logic              ff2 [NP];

  pnode_frame_ctrl #(.NPAIR(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .llr_c     (llr_c),
    .llr_d     (llr_d),
    .frozen1   (frozen1),
    .frozen2   (frozen2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decision: a positive LLR means hard bit 1.
  function automatic logic [2*NP-1:0] model_frame();
    logic [2*NP-1:0] r;
    int  cm;
    int  dm;
    bit  c_pos;
    bit  d_pos;
    r = '0;
    for (int k = 0; k < NP; k++) begin
      cm    = int'(fc[k]) % 128;
      dm    = int'(fd[k]) % 128;
      c_pos = (int'(fc[k]) < 128);
      d_pos = (int'(fd[k]) < 128);
      r[2*k]   = !ff1[k] && (c_pos != d_pos);
      r[2*k+1] = !ff2[k] && (cm > dm) && (d_pos || (ff1[k] && c_pos));
    end
    return r;
  endfunction

  task automatic gen_random();
    int mode;
    for (int k = 0; k < NP; k++) begin
      mode  = int'($urandom_range(0, 3));
      fc[k] = 8'($urandom);
      fd[k] = 8'($urandom);
      if (mode == 1) fd[k] = {fd[k][7], fc[k][6:0]};
      if (mode == 2) fc[k] = {fc[k][7], 7'd0};
      ff1[k] = 1'($urandom);
      ff2[k] = 1'($urandom);
    end
  endtask

  task automatic set_const(input logic [7:0] c, input logic [7:0] d, input logic f1, input logic f2);
    for (int k = 0; k < NP; k++) begin
      fc[k] = c; fd[k] = d; ff1[k] = f1; ff2[k] = f2;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the last beat.
  task automatic send_frame(input bit gaps);
    for (int k = 0; k < NP; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        llr_c = 8'($urandom); llr_d = 8'($urandom);
        frozen1 = 1'($urandom); frozen2 = 1'($urandom);
        @(negedge clk);
      end
      if (k > 0) chk("busy_load", 64'(busy), 64'(1'b1));
      chk("in_ready_load", 64'(in_ready), 64'(1'b1));
      in_valid = 1'b1;
      llr_c = fc[k]; llr_d = fd[k]; frozen1 = ff1[k]; frozen2 = ff2[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // RUN with ignored input traffic, latency, OUT hold and handshake.
  task automatic finish_frame(input int hold);
    logic [2*NP-1:0] eb;
    int lat;
    eb  = model_frame();
    lat = 0;
    while (!out_valid && lat < LIMIT) begin
      chk("in_ready_run", 64'(in_ready), 64'(1'b0));
      chk("busy_run", 64'(busy), 64'(1'b1));
      in_valid = 1'b1;
      llr_c = 8'($urandom); llr_d = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(NP));
    if (!out_valid) return;
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 64'(out_valid), 64'(1'b1));
      chk("hold_bits", 64'(out_bits), 64'(eb));
      chk("hold_in_ready", 64'(in_ready), 64'(1'b0));
      chk("hold_frame_cnt", 64'(frame_cnt), 64'(exp_fc));
      @(negedge clk);
    end
    chk("out_valid", 64'(out_valid), 64'(1'b1));
    chk("out_bits", 64'(out_bits), 64'(eb));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_fc    = exp_fc + 8'd1;
    chk("post_valid", 64'(out_valid), 64'(1'b0));
    chk("post_frame_cnt", 64'(frame_cnt), 64'(exp_fc));
    chk("post_busy", 64'(busy), 64'(1'b0));
    chk("post_in_ready", 64'(in_ready), 64'(1'b1));
    chk("post_bits_kept", 64'(out_bits), 64'(eb));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    llr_c = 8'd0; llr_d = 8'd0; frozen1 = 1'b0; frozen2 = 1'b0;
    exp_fc = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
    chk("rst_frame_cnt", 64'(frame_cnt), 64'(8'd0));
    chk("rst_bits", 64'(out_bits), 64'(16'h0000));
    rst_n = 1'b1;

    // +5 / -3, nothing frozen: every pair decodes to (1,0).
    set_const(8'h05, 8'h83, 1'b0, 1'b0);
    send_frame(1'b0);
    finish_frame(0);
    chk("const_bits", 64'(out_bits), 64'(16'h5555));

    // Same data with in_valid toggling between beats.
    send_frame(1'b1);
    finish_frame(1);
    chk("gap_bits", 64'(out_bits), 64'(16'h5555));

    // Directed pairs, with the consumer stalling for 20 cycles.
    set_const(8'h00, 8'h00, 1'b1, 1'b1);
    fc[0] = 8'h05; fd[0] = 8'h03; ff1[0] = 1'b0; ff2[0] = 1'b0;
    fc[1] = 8'h05; fd[1] = 8'h03; ff1[1] = 1'b1; ff2[1] = 1'b1;
    fc[2] = 8'h04; fd[2] = 8'h84; ff1[2] = 1'b1; ff2[2] = 1'b0;
    fc[3] = 8'h05; fd[3] = 8'h83; ff1[3] = 1'b0; ff2[3] = 1'b0;
    send_frame(1'b0);
    finish_frame(20);
    chk("directed_bits", 64'(out_bits), 64'(16'h0042));

    // Reset while RUN is at pair 3.
    gen_random();
    send_frame(1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_valid", 64'(out_valid), 64'(1'b0));
    chk("midrun_busy", 64'(busy), 64'(1'b0));
    chk("midrun_frame_cnt", 64'(frame_cnt), 64'(8'd0));
    chk("midrun_bits", 64'(out_bits), 64'(16'h0000));
    chk("midrun_in_ready", 64'(in_ready), 64'(1'b1));
    @(negedge clk);
    rst_n  = 1'b1;
    exp_fc = 8'd0;
    gen_random();
    send_frame(1'b0);
    finish_frame(0);

    // Random frames; enough of them to wrap frame_cnt.
    for (int f = 0; f < 260; f++) begin
      gen_random();
      send_frame(1'($urandom));
      finish_frame(int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
